hsv_to_rgb_led: RTL and testbench
=================================

Name: hsv_to_rgb_led

Overview:
- Downstream stage of the button/mode HSV editor.
- Consumes its 9-bit Hue (0..360), Saturation (0..100) and Value (0..100) outputs.
- Converts them in a fixed-latency pipeline to 8-bit R/G/B and drives three PWM pins for the on-board RGB LED.
- Flags each new colour with a one-cycle rgb_valid pulse.

Parameters:
- PWM_DIV, 40, system clocks per PWM slot. At 10 MHz this gives about 980 Hz at the LED.
- LED_ACTIVE_LOW, 0, when 1 the led_r/led_g/led_b pins are inverted.

Ports:
- clk  in  1  system clock (10 MHz).
- reset  in  1  asynchronous, active-low reset. Clock and reset are one clock domain, named as the codebase does; polarity and synchronicity are fixed.
- Hue  in  9  hue in degrees, 0..360.
- Saturation  in  9  saturation, 0..100.
- Value  in  9  value, 0..100.
- R  out  8  red component.
- G  out  8  green component.
- B  out  8  blue component.
- rgb_valid  out  1  one-cycle pulse when R/G/B change to a newly converted triplet.
- led_r  out  1  red PWM pin.
- led_g  out  1  green PWM pin.
- led_b  out  1  blue PWM pin.

Behaviour:
- Reset (reset=0, async): R=G=B=0; rgb_valid=0; all pipeline valid bits=0; PWM counter, prescaler and duty registers=0; LED pins inactive (0, or 1 if LED_ACTIVE_LOW). The previous-triplet register is set to all-ones (0x1FF,0x1FF,0x1FF), so the first sample after reset always counts as a change.
- Stage 0 (input register), every clock:
  - H' = Hue-360 if Hue>=360, else Hue. 9-bit input, so max 511 maps to 151.
  - S' = min(Saturation,100); V' = min(Value,100).
  - chg = (H',S',V') differs from the previous triplet; then the previous triplet is updated.
  - chg enters the pipeline valid chain.
- Stage 1:
  - sector = H'/60 (0..5); f = H' - 60*sector (0..59).
  - Vs = (V'*255+50)/100, range 0..255.
- Stage 2: C = (Vs*S'+50)/100.
- Stage 3:
  - Xr = (C*f+30)/60; Xf = C-Xr; m = Vs-C.
- Stage 4 (output):
  - sector 0: (C,Xr,0)
  - sector 1: (Xf,C,0)
  - sector 2: (0,C,Xr)
  - sector 3: (0,Xf,C)
  - sector 4: (Xr,0,C)
  - sector 5: (C,0,Xf)
  - m is added to each component, giving R,G,B. The sum never exceeds 255; no saturation logic is needed.
  - R/G/B load and rgb_valid=1 only when this stage's valid bit is set; otherwise R/G/B hold and rgb_valid=0.
- Latency: a triplet stable before clock edge N shows on R/G/B, with rgb_valid high, after edge N+4.
- Throughput is one triplet per clock. Back-to-back changes give consecutive rgb_valid pulses, each with its own result.
- Divisions by the constants 100 and 60 must match the floor formulas above bit-exactly. Constant-reciprocal multiply or LUT implementations are allowed.
- PWM:
  - The prescaler counts 0..PWM_DIV-1 and issues a tick on wrap.
  - On each tick, pwm_cnt counts 0..254 and wraps to 0.
  - When pwm_cnt wraps to 0 on a tick, duty_r/g/b load from R/G/B. Duty never changes mid-period, so the pins are glitch-free.
  - A pin is active while pwm_cnt < duty: duty 0 is never active, duty 255 is always active.
- Reset mid-pipeline discards every in-flight triplet; no rgb_valid follows the release of reset until a fresh sample has passed through the 5 stages.

Decomposition:
- Shared package hsv_pkg holds:
  - constants HUE_MAX=360, SV_MAX=100, SECTOR_DEG=60, PWM_TOP=254;
  - 9-bit hsv_t and 8-bit rgb8_t typedefs, reused by the HSV editor.
- One sub-module, rgb_pwm: prescaler, pwm_cnt, duty latch and three comparators, instantiated once with PWM_DIV and LED_ACTIVE_LOW.
- The conversion pipeline stays in the top module.

Test Plan:
- Reset release, then Hue=0,S=100,V=100 → 5 edges later R/G/B=255/0/0, rgb_valid pulses once; holding inputs gives no further pulses.
- Hue=120 then 240, S=100,V=100 on consecutive cycles → two consecutive rgb_valid pulses with 0/255/0 then 0/0/255.
- Hue=30,S=100,V=100 → 255/128/0; Hue=360 → identical to Hue=0 (255/0/0), and no pulse if the previous sample was Hue=0.
- S=0,V=50, any Hue → 128/128/128; Saturation=150,Value=200 → clamped, result equal to S=100,V=100.
- PWM_DIV=1, R=0,G=255,B=128 → over one 255-clock period led_r never high, led_g always high, led_b high for 128 clocks. An R change mid-period takes effect only from the next period.
- Assert reset 2 cycles after a Hue change → R/G/B=0, pins inactive, no stale rgb_valid after release.

Source files
------------

// File: rtl/hsv_pkg.sv
// Shared HSV/RGB types, range constants and constant-divide helpers.
// Pure declarations, no latency.
// No flow control.
//
// Reused by the button/mode HSV editor (hsv_t) and the LED output stage.
package hsv_pkg;

    localparam int HUE_MAX    = 360;
    localparam int SV_MAX     = 100;
    localparam int SECTOR_DEG = 60;
    localparam int PWM_TOP    = 254;

    typedef logic [8:0] hsv_t;
    typedef logic [7:0] rgb8_t;
    typedef logic [6:0] pct_t;     // 0..100 after clamping
    typedef logic [2:0] sector_t;  // 0..5
    typedef logic [5:0] frac_t;    // 0..59 degrees inside a sector

    // Stage 1 -> 2: sector split done, value scaled to 0..255
    typedef struct packed {
        logic    vld;
        sector_t sector;
        frac_t   f;
        rgb8_t   vs;
        pct_t    s;
    } st1_t;

    // Stage 2 -> 3: chroma known
    typedef struct packed {
        logic    vld;
        sector_t sector;
        frac_t   f;
        rgb8_t   vs;
        rgb8_t   c;
    } st2_t;

    // Stage 3 -> 4: all component magnitudes known, only the mux is left
    typedef struct packed {
        logic    vld;
        sector_t sector;
        rgb8_t   c;
        rgb8_t   xr;
        rgb8_t   xf;
        rgb8_t   m;
    } st3_t;

    // Floor division by constants; every caller's numerator stays below 2^16
    // and every quotient below 256, so the truncating casts are lossless.
    function automatic rgb8_t div100(input logic [15:0] num);
        return rgb8_t'(num / 16'd100);
    endfunction

    function automatic rgb8_t div60(input logic [15:0] num);
        return rgb8_t'(num / 16'd60);
    endfunction

endpackage

// File: rtl/hsv_to_rgb_led_if.sv
// Bundle of HSV inputs, converted RGB outputs and LED pins.
// Wiring only, no latency.
// No flow control: rgb_valid is a pure strobe.
//
// master: HSV source / observer, slave: the converter.
interface hsv_to_rgb_led_if;
    import hsv_pkg::*;

    hsv_t  Hue;
    hsv_t  Saturation;
    hsv_t  Value;
    rgb8_t R;
    rgb8_t G;
    rgb8_t B;
    logic  rgb_valid;
    logic  led_r;
    logic  led_g;
    logic  led_b;

    modport master (
        output Hue, Saturation, Value,
        input  R, G, B, rgb_valid, led_r, led_g, led_b
    );

    modport slave (
        input  Hue, Saturation, Value,
        output R, G, B, rgb_valid, led_r, led_g, led_b
    );

endinterface

// File: rtl/rgb_pwm.sv
// Three-channel 255-slot PWM for the RGB LED, duty latched once per period.
// Pins are registered: they follow (pwm_cnt < duty) one clock later.
// No backpressure; new duties are sampled only when pwm_cnt wraps to 0.
//
// Ports: clk, reset (async active-low), i_r/i_g/i_b duty sources,
//        o_led_r/o_led_g/o_led_b PWM pins (inverted when LED_ACTIVE_LOW).
module rgb_pwm
    import hsv_pkg::*;
#(
    parameter int PWM_DIV        = 40,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic  clk,
    input  logic  reset,
    input  rgb8_t i_r,
    input  rgb8_t i_g,
    input  rgb8_t i_b,
    output logic  o_led_r,
    output logic  o_led_g,
    output logic  o_led_b
);

    localparam int               PRE_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);
    localparam rgb8_t            CNT_TOP  = rgb8_t'(PWM_TOP);

    logic [PRE_W-1:0] r_pre;
    rgb8_t            r_cnt;
    rgb8_t            r_duty_r;
    rgb8_t            r_duty_g;
    rgb8_t            r_duty_b;
    logic             r_led_r;
    logic             r_led_g;
    logic             r_led_b;
    logic             w_tick;

    assign w_tick = (r_pre == PRE_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre    <= '0;
            r_cnt    <= '0;
            r_duty_r <= '0;
            r_duty_g <= '0;
            r_duty_b <= '0;
            r_led_r  <= LED_ACTIVE_LOW;
            r_led_g  <= LED_ACTIVE_LOW;
            r_led_b  <= LED_ACTIVE_LOW;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
            if (w_tick) begin
                if (r_cnt == CNT_TOP) begin
                    // Period boundary: the only place duties may change.
                    r_cnt    <= '0;
                    r_duty_r <= i_r;
                    r_duty_g <= i_g;
                    r_duty_b <= i_b;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
            // pwm_cnt tops out at 254, so duty 255 is on for the whole period.
            r_led_r <= (r_cnt < r_duty_r) ^ LED_ACTIVE_LOW;
            r_led_g <= (r_cnt < r_duty_g) ^ LED_ACTIVE_LOW;
            r_led_b <= (r_cnt < r_duty_b) ^ LED_ACTIVE_LOW;
        end
    end

    assign o_led_r = r_led_r;
    assign o_led_g = r_led_g;
    assign o_led_b = r_led_b;

endmodule

// File: rtl/hsv_to_rgb_led.sv
// HSV (deg, %, %) to 8-bit RGB converter driving the on-board RGB LED PWM.
// Latency 5 registers: input stable before edge N appears after edge N+4.
// No backpressure; one triplet per clock, rgb_valid strobes on each change.
//
// Ports: clk, reset (async active-low), bus (slave): Hue/Saturation/Value in,
//        R/G/B, rgb_valid and led_r/led_g/led_b out.
module hsv_to_rgb_led
    import hsv_pkg::*;
#(
    parameter int PWM_DIV        = 40,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    hsv_to_rgb_led_if.slave bus
);

    // ---------------- stage 0: wrap / clamp / change detect ----------------
    hsv_t w_h;
    hsv_t w_s;
    hsv_t w_v;
    logic w_chg;

    // r_h0/r_s0/r_v0 double as the previous-triplet register. Resetting them
    // to all-ones (unreachable after wrap/clamp) forces the first sample after
    // reset to register as a change.
    hsv_t r_h0;
    hsv_t r_s0;
    hsv_t r_v0;
    logic r_vld0;

    assign w_h   = (bus.Hue >= hsv_t'(HUE_MAX)) ? bus.Hue - hsv_t'(HUE_MAX) : bus.Hue;
    assign w_s   = (bus.Saturation > hsv_t'(SV_MAX)) ? hsv_t'(SV_MAX) : bus.Saturation;
    assign w_v   = (bus.Value > hsv_t'(SV_MAX)) ? hsv_t'(SV_MAX) : bus.Value;
    assign w_chg = (w_h != r_h0) || (w_s != r_s0) || (w_v != r_v0);

    // ---------------- stage 1: sector split, scale value ----------------
    sector_t w_sector;
    hsv_t    w_base;
    rgb8_t   w_vs;
    st1_t    r_st1;

    always_comb begin
        w_sector = 3'd0;
        w_base   = '0;
        if (r_h0 >= hsv_t'(5 * SECTOR_DEG)) begin
            w_sector = 3'd5;
            w_base   = hsv_t'(5 * SECTOR_DEG);
        end else if (r_h0 >= hsv_t'(4 * SECTOR_DEG)) begin
            w_sector = 3'd4;
            w_base   = hsv_t'(4 * SECTOR_DEG);
        end else if (r_h0 >= hsv_t'(3 * SECTOR_DEG)) begin
            w_sector = 3'd3;
            w_base   = hsv_t'(3 * SECTOR_DEG);
        end else if (r_h0 >= hsv_t'(2 * SECTOR_DEG)) begin
            w_sector = 3'd2;
            w_base   = hsv_t'(2 * SECTOR_DEG);
        end else if (r_h0 >= hsv_t'(SECTOR_DEG)) begin
            w_sector = 3'd1;
            w_base   = hsv_t'(SECTOR_DEG);
        end
    end

    assign w_vs = div100(16'(r_v0) * 16'd255 + 16'd50);

    // ---------------- stage 2: chroma ----------------
    rgb8_t w_c;
    st2_t  r_st2;

    assign w_c = div100(16'(r_st1.vs) * 16'(r_st1.s) + 16'd50);

    // ---------------- stage 3: rising/falling ramp, offset ----------------
    rgb8_t w_xr;
    st3_t  r_st3;

    assign w_xr = div60(16'(r_st2.c) * 16'(r_st2.f) + 16'd30);

    // ---------------- stage 4: sector mux plus offset ----------------
    rgb8_t w_cm;
    rgb8_t w_xrm;
    rgb8_t w_xfm;
    rgb8_t w_r;
    rgb8_t w_g;
    rgb8_t w_b;
    rgb8_t r_r;
    rgb8_t r_g;
    rgb8_t r_b;
    logic  r_valid;

    // Each sum is bounded by Vs <= 255, so plain 8-bit adds never wrap.
    assign w_cm  = r_st3.c  + r_st3.m;
    assign w_xrm = r_st3.xr + r_st3.m;
    assign w_xfm = r_st3.xf + r_st3.m;

    always_comb begin
        w_r = r_st3.m;
        w_g = r_st3.m;
        w_b = r_st3.m;
        case (r_st3.sector)
            3'd0:    begin w_r = w_cm;  w_g = w_xrm; end
            3'd1:    begin w_r = w_xfm; w_g = w_cm;  end
            3'd2:    begin w_g = w_cm;  w_b = w_xrm; end
            3'd3:    begin w_g = w_xfm; w_b = w_cm;  end
            3'd4:    begin w_r = w_xrm; w_b = w_cm;  end
            3'd5:    begin w_r = w_cm;  w_b = w_xfm; end
            default: begin end
        endcase
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h0    <= '1;
            r_s0    <= '1;
            r_v0    <= '1;
            r_vld0  <= 1'b0;
            r_st1   <= '0;
            r_st2   <= '0;
            r_st3   <= '0;
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_h0   <= w_h;
            r_s0   <= w_s;
            r_v0   <= w_v;
            r_vld0 <= w_chg;

            r_st1.vld    <= r_vld0;
            r_st1.sector <= w_sector;
            r_st1.f      <= frac_t'(r_h0 - w_base);
            r_st1.vs     <= w_vs;
            r_st1.s      <= pct_t'(r_s0);

            r_st2.vld    <= r_st1.vld;
            r_st2.sector <= r_st1.sector;
            r_st2.f      <= r_st1.f;
            r_st2.vs     <= r_st1.vs;
            r_st2.c      <= w_c;

            r_st3.vld    <= r_st2.vld;
            r_st3.sector <= r_st2.sector;
            r_st3.c      <= r_st2.c;
            r_st3.xr     <= w_xr;
            r_st3.xf     <= r_st2.c - w_xr;
            r_st3.m      <= r_st2.vs - r_st2.c;

            r_valid <= r_st3.vld;
            if (r_st3.vld) begin
                r_r <= w_r;
                r_g <= w_g;
                r_b <= w_b;
            end
        end
    end

    assign bus.R         = r_r;
    assign bus.G         = r_g;
    assign bus.B         = r_b;
    assign bus.rgb_valid = r_valid;

    // ---------------- LED PWM ----------------
    logic w_led_r;
    logic w_led_g;
    logic w_led_b;

    rgb_pwm #(
        .PWM_DIV        (PWM_DIV),
        .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
    ) u_pwm (
        .clk     (clk),
        .reset   (reset),
        .i_r     (r_r),
        .i_g     (r_g),
        .i_b     (r_b),
        .o_led_r (w_led_r),
        .o_led_g (w_led_g),
        .o_led_b (w_led_b)
    );

    assign bus.led_r = w_led_r;
    assign bus.led_g = w_led_g;
    assign bus.led_b = w_led_b;

endmodule

// File: tb/tb_hsv_to_rgb_led.sv
// Directed bench for hsv_to_rgb_led with hand-computed RGB vectors.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
// PWM checked with PWM_DIV=1 so one period is 255 clocks.
module tb_hsv_to_rgb_led;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc;

    always #50 clk = ~clk;

    hsv_to_rgb_led_if bus();

    hsv_to_rgb_led #(
        .PWM_DIV        (1),
        .LED_ACTIVE_LOW (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock edges since reset release; PWM periods start after edges 255*j.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic apply(input int h, input int s, input int v);
        bus.Hue        = 9'(h);
        bus.Saturation = 9'(s);
        bus.Value      = 9'(v);
    endtask

    function automatic logic [31:0] rgb_now();
        return {8'h00, bus.R, bus.G, bus.B};
    endfunction

    // Apply a triplet, expect silence for 4 samples then a pulse with rgb.
    task automatic expect_conv(input string tag, input int h, input int s, input int v,
                               input logic [23:0] rgb);
        apply(h, s, v);
        step(5);
        check({tag, "_vld"}, {31'd0, bus.rgb_valid}, 32'd1);
        check({tag, "_rgb"}, rgb_now(), {8'h00, rgb});
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (bus.rgb_valid === 1'b1) cnt++;
        end
    endtask

    // Step to the next falling edge that follows a PWM period boundary.
    task automatic align_period(input string tag);
        int budget;
        budget = 0;
        do begin
            step(1);
            budget++;
        end while ((cyc % 255) != 0 && budget < 600);
        check({tag, "_align"}, {31'd0, (cyc % 255) == 0}, 32'd1);
    endtask

    // Count pin-high samples over one PWM period, optionally applying a new
    // Hue partway through (mid_h < 0 means no change).
    task automatic pwm_period(input int mid_h, output int nr, output int ng, output int nb);
        nr = 0; ng = 0; nb = 0;
        for (int i = 0; i < 255; i++) begin
            if (i == 50 && mid_h >= 0) apply(mid_h, 100, 100);
            step(1);
            if (bus.led_r === 1'b1) nr++;
            if (bus.led_g === 1'b1) ng++;
            if (bus.led_b === 1'b1) nb++;
        end
    endtask

    typedef struct {
        int          h;
        int          s;
        int          v;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs[5];
    int   np;
    int   pr, pg, pb;

    initial begin
        // Hand-derived from the floor formulas.
        vecs[0] = '{200,  50,  80, 24'h66aacc}; // Vs=204 C=102 f=20 Xr=34 m=102
        vecs[1] = '{511, 100, 100, 24'h00ff84}; // 511 wraps to 151: sector 2, Xr=132
        vecs[2] = '{359, 100, 100, 24'hff0004}; // sector 5 f=59: Xr=251, Xf=4
        vecs[3] = '{300, 100, 100, 24'hff00ff}; // sector 5 f=0: Xf=C
        vecs[4] = '{ 60, 100, 100, 24'hffff00}; // sector 1 f=0: Xf=C

        reset = 1'b0;
        apply(0, 100, 100);
        step(3);
        check("reset_rgb", rgb_now(), 32'h0);
        check("reset_vld", {31'd0, bus.rgb_valid}, 32'd0);
        check("reset_leds", {29'd0, bus.led_r, bus.led_g, bus.led_b}, 32'd0);

        // First sample after release: silent 4 samples, pulse on the 5th.
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            check("first_latency_quiet", {31'd0, bus.rgb_valid}, 32'd0);
        end
        step(1);
        check("first_vld", {31'd0, bus.rgb_valid}, 32'd1);
        check("first_rgb", rgb_now(), 32'h00ff0000);
        count_pulses(8, np);
        check("hold_no_pulse", np, 0);

        // Back-to-back changes give back-to-back pulses.
        apply(120, 100, 100);
        step(1);
        apply(240, 100, 100);
        step(4);
        check("b2b_vld0", {31'd0, bus.rgb_valid}, 32'd1);
        check("b2b_rgb0", rgb_now(), 32'h0000ff00);
        step(1);
        check("b2b_vld1", {31'd0, bus.rgb_valid}, 32'd1);
        check("b2b_rgb1", rgb_now(), 32'h000000ff);
        step(1);
        check("b2b_end", {31'd0, bus.rgb_valid}, 32'd0);

        // Mid-sector hue, then 360 aliasing 0 with no pulse.
        expect_conv("hue30", 30, 100, 100, 24'hff8000);
        expect_conv("hue0", 0, 100, 100, 24'hff0000);
        apply(360, 100, 100);
        count_pulses(8, np);
        check("hue360_no_pulse", np, 0);
        check("hue360_rgb", rgb_now(), 32'h00ff0000);

        // Grey is hue-independent; out-of-range S/V clamp to 100.
        expect_conv("grey_h200", 200, 0, 50, 24'h808080);
        expect_conv("grey_h77", 77, 0, 50, 24'h808080);
        expect_conv("clamp", 0, 150, 200, 24'hff0000);

        foreach (vecs[k]) expect_conv($sformatf("vec%0d", k), vecs[k].h, vecs[k].s,
                                      vecs[k].v, vecs[k].rgb);

        // PWM: R=0 G=255 B=128, then an R change partway through a period.
        expect_conv("pwm_src", 150, 100, 100, 24'h00ff80);
        align_period("pwm");
        pwm_period(-1, pr, pg, pb);
        check("pwm_r_off", pr, 0);
        check("pwm_g_on", pg, 255);
        check("pwm_b_half", pb, 128);
        pwm_period(90, pr, pg, pb);
        check("pwm_mid_r_old", pr, 0);
        check("pwm_mid_b_old", pb, 128);
        check("pwm_mid_rgb", rgb_now(), 32'h007fff00);
        pwm_period(-1, pr, pg, pb);
        check("pwm_next_r_new", pr, 127);
        check("pwm_next_g", pg, 255);
        check("pwm_next_b_new", pb, 0);

        // Reset two cycles into a conversion discards it.
        apply(10, 100, 100);
        step(2);
        reset = 1'b0;
        #1;
        check("midrst_rgb", rgb_now(), 32'h0);
        check("midrst_vld", {31'd0, bus.rgb_valid}, 32'd0);
        check("midrst_leds", {29'd0, bus.led_r, bus.led_g, bus.led_b}, 32'd0);
        step(2);
        reset = 1'b1;
        np = 0;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            if (bus.rgb_valid === 1'b1) np++;
        end
        check("midrst_no_stale", np, 0);
        step(1);
        check("midrst_fresh_vld", {31'd0, bus.rgb_valid}, 32'd1);
        check("midrst_fresh_rgb", rgb_now(), 32'h00ff2b00); // f=10: Xr=43

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
